// File: rtl/net_share_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : net_share_arb_pkg
//  Purpose  : Shared types and constants for the shared-net arbiter: FSM
//             state encoding, beat-counter width and watchdog limit.
//  Revision : 1.0  initial release
// ============================================================================
package net_share_arb_pkg;

    // Arbiter FSM: IDLE picks a winner, BUSY lets the winner drive the net
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Beat counter is 4 bits wide so MAX_BEATS can reach 15
    localparam int BEAT_W = 4;

    // Consecutive stalled BUSY cycles before the watchdog forces a release
    localparam int WD_CYCLES = 16;

    // Width of the watchdog counter; must hold WD_CYCLES
    localparam int WD_W = 5;

endpackage : net_share_arb_pkg
`default_nettype wire

// File: rtl/net_share_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin picker. Scans the request vector
//             starting at ptr_i (wrapping) and returns the first set
//             requester as a one-hot vector plus its index.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_o
);

    // One extra bit so ptr + offset never overflows before the wrap
    localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W:0]   cand;
    logic [PTR_W-1:0] cand_idx;

    // Walk offsets 0..NUM_REQ-1 from the pointer; first requester found wins
    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = '0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            cand_idx = cand[PTR_W-1:0];
            if (!any_o && req_i[cand_idx]) begin
                any_o           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/net_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : net_share_arbiter
//  Purpose  : Round-robin arbiter granting one of NUM_REQ requesters the
//             shared output net for up to MAX_BEATS transfers per grant.
//             Optional stall watchdog enabled by NET_SHARE_ARB_WATCHDOG_EN.
//  Revision : 1.0  initial release
// ============================================================================
module net_share_arbiter
    import net_share_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic                      timeout_err
);

    localparam int                PTR_W     = $clog2(NUM_REQ);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BEATS - 1);
    localparam logic [PTR_W-1:0]  IDX_LAST  = PTR_W'(NUM_REQ - 1);

    state_t              state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [PTR_W-1:0]    idx_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [BEAT_W-1:0]   beat_d;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [PTR_W-1:0]    rr_ptr_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_any;

    logic                xfer;
    logic                last_beat;
    logic                rel;
    logic                wd_fire;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Granted requester drives the net; grant is zero in IDLE so the net reads 0
    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            out_data = out_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{grant_q[i]}});
        end
    end

    assign grant     = grant_q;
    assign out_valid = |(req & grant_q);
    assign xfer      = out_valid && out_ready;
    assign last_beat = xfer && (beat_q == BEAT_LAST);
    assign beat_d    = beat_q + BEAT_W'(1);
    assign rr_ptr_d  = (idx_q == IDX_LAST) ? '0 : idx_q + PTR_W'(1);

    // In BUSY, a low granted request means the owner let go of the net
    assign rel = (state_q == ST_BUSY) && (!out_valid || last_beat || wd_fire);

`ifdef NET_SHARE_ARB_WATCHDOG_EN
    logic [WD_W-1:0] wd_q;
    logic            timeout_q;
    logic            stall;

    assign stall   = (state_q == ST_BUSY) && out_valid && !out_ready;
    assign wd_fire = stall && (wd_q == WD_W'(WD_CYCLES - 1));

    // Count consecutive stalled cycles; fire a one-cycle timeout on the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_fire;
            if (stall && !wd_fire) begin
                wd_q <= wd_q + WD_W'(1);
            end else begin
                wd_q <= '0;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Arbitration FSM: pick in IDLE, count beats and release in BUSY
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            beat_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_q <= ST_BUSY;
                        grant_q <= pick_gnt;
                        idx_q   <= pick_idx;
                        beat_q  <= '0;
                    end
                end
                ST_BUSY: begin
                    if (rel) begin
                        state_q  <= ST_IDLE;
                        grant_q  <= '0;
                        beat_q   <= '0;
                        rr_ptr_q <= rr_ptr_d;
                    end else if (xfer) begin
                        beat_q <= beat_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    beat_q  <= '0;
                end
            endcase
        end
    end

endmodule : net_share_arbiter
`default_nettype wire

// File: tb/tb_net_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_net_share_arbiter
//  Purpose  : Self-checking bench for net_share_arbiter. Random and directed
//             stimulus compared each cycle against an integer-level model of
//             the arbitration rules. Honours NET_SHARE_ARB_WATCHDOG_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_net_share_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BEATS = 4;
    localparam int WD_LIMIT  = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_ready;
    logic                      timeout_err;

    net_share_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: owner index (-1 = nobody), beats taken, next start
    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;
    int m_wd    = 0;
    bit m_tmo   = 1'b0;
    bit m_known = 1'b0;

    // Optional directed expectation for grant on the current step
    bit                 dir_en  = 1'b0;
    logic [NUM_REQ-1:0] dir_exp = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic [NUM_REQ-1:0] rq, input logic rdy);
        bit v, xf, stall, fire, found;
        int c;
        if (r) begin
            m_owner = -1; m_beats = 0; m_ptr = 0; m_wd = 0; m_tmo = 1'b0; m_known = 1'b1;
        end else if (m_known) begin
            m_tmo = 1'b0;
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 0; k < NUM_REQ; k++) begin
                    c = (m_ptr + k) % NUM_REQ;
                    if (!found && rq[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                        m_beats = 0;
                    end
                end
            end else begin
                v     = rq[m_owner];
                xf    = v && rdy;
                stall = v && !rdy;
                fire  = 1'b0;
                if (xf) m_beats++;
`ifdef NET_SHARE_ARB_WATCHDOG_EN
                if (stall) m_wd++; else m_wd = 0;
                if (m_wd >= WD_LIMIT) fire = 1'b1;
`else
                if (stall) m_wd = 0;
`endif
                if (!v || m_beats >= MAX_BEATS || fire) begin
                    m_ptr   = (m_owner + 1) % NUM_REQ;
                    m_owner = -1;
                    m_beats = 0;
                    m_wd    = 0;
                    m_tmo   = fire;
                end
            end
        end
    endtask

    // One clock: drive at negedge, check 1 ns later, advance model at posedge
    task automatic step(input logic r, input logic [NUM_REQ-1:0] rq, input logic rdy);
        logic [NUM_REQ-1:0] eg;
        logic               ev;
        logic [DATA_W-1:0]  ed;
        rst       = r;
        req       = rq;
        out_ready = rdy;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
        #1;
        if (m_known) begin
            eg = '0; ev = 1'b0; ed = '0;
            if (m_owner >= 0) begin
                eg[m_owner] = 1'b1;
                ev          = rq[m_owner];
                ed          = req_data[m_owner*DATA_W +: DATA_W];
            end
            check("grant",       32'(grant),       32'(eg));
            check("out_valid",   32'(out_valid),   32'(ev));
            check("out_data",    32'(out_data),    32'(ed));
            check("timeout_err", 32'(timeout_err), 32'(m_tmo));
            if (dir_en) check("dir_grant", 32'(grant), 32'(dir_exp));
        end
        @(posedge clk);
        model_update(r, rq, rdy);
        @(negedge clk);
    endtask

    logic [NUM_REQ-1:0] rq_s;
    logic               rdy_s;
    int                 mode;
    int                 m;

    initial begin
        rst = 1'b1; req = '0; out_ready = 1'b0; req_data = '0;
        @(negedge clk);
        step(1'b1, '0, 1'b1);

        // Single requester held: 4 beats, one idle cycle, re-grant to 0
        step(1'b0, 4'b0000, 1'b1);
        for (int n = 0; n < 12; n++) begin
            m       = n - 1;
            dir_en  = 1'b1;
            dir_exp = (n == 0 || (m % 5) == 4) ? 4'b0000 : 4'b0001;
            step(1'b0, 4'b0001, 1'b1);
        end
        dir_en = 1'b0;

        // All requesting: rotation 0,1,2,3,0 with 4 beats each and idle gaps
        step(1'b1, '0, 1'b1);
        for (int n = 0; n < 22; n++) begin
            m       = n - 1;
            dir_en  = 1'b1;
            dir_exp = (n == 0 || (m % 5) == 4) ? 4'b0000 : NUM_REQ'(1 << ((m / 5) % 4));
            step(1'b0, 4'b1111, 1'b1);
        end
        dir_en = 1'b0;

        // Long stall while granted: watchdog release or indefinite hold
        step(1'b1, '0, 1'b1);
        for (int n = 0; n < 24; n++) step(1'b0, 4'b0100, 1'b0);
        for (int n = 0; n < 4; n++)  step(1'b0, 4'b0000, 1'b1);

        // Randomized phases with sticky requests and occasional resets
        rq_s  = '0;
        rdy_s = 1'b1;
        for (int p = 0; p < 60; p++) begin
            mode = $urandom_range(0, 3);
            for (int n = 0; n < 40; n++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if ($urandom_range(0, 7) == 0) rq_s[i] = ~rq_s[i];
                end
                case (mode)
                    0:       rdy_s = 1'b1;
                    1:       rdy_s = ($urandom_range(0, 3) != 0);
                    2:       rdy_s = ($urandom_range(0, 1) != 0);
                    default: rdy_s = ($urandom_range(0, 19) == 0);
                endcase
                step(($urandom_range(0, 63) == 0), rq_s, rdy_s);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_net_share_arbiter
`default_nettype wire
